// File: rtl/i_buffer_pkg.sv
// Shared widths and entry layout for the decode-to-dispatch instruction buffer.
package i_buffer_pkg;

  localparam int unsigned OPT_WID    = 7;
  localparam int unsigned FUNCT3_WID = 3;
  localparam int unsigned FUNCT6_WID = 6;
  localparam int unsigned REG_WID    = 6;
  localparam int unsigned XLEN       = 32;

  // One buffered instruction: 7+3+6+6+6+6+32 = 66 bits
  localparam int unsigned IB_ENTRY_WID =
    OPT_WID + FUNCT3_WID + FUNCT6_WID + 3 * REG_WID + XLEN;

  // Field-pack bit offsets, shared with dispatch; opt sits in the MSBs
  localparam int unsigned IB_IMM_LSB    = 0;
  localparam int unsigned IB_RD_LSB     = IB_IMM_LSB + XLEN;
  localparam int unsigned IB_RS2_LSB    = IB_RD_LSB + REG_WID;
  localparam int unsigned IB_RS1_LSB    = IB_RS2_LSB + REG_WID;
  localparam int unsigned IB_FUNCT6_LSB = IB_RS1_LSB + REG_WID;
  localparam int unsigned IB_FUNCT3_LSB = IB_FUNCT6_LSB + FUNCT6_WID;
  localparam int unsigned IB_OPT_LSB    = IB_FUNCT3_LSB + FUNCT3_WID;

  // Struct view of the same layout (first member = MSBs)
  typedef struct packed {
    logic [OPT_WID-1:0]    opt;
    logic [FUNCT3_WID-1:0] funct3;
    logic [FUNCT6_WID-1:0] funct6;
    logic [REG_WID-1:0]    rs1;
    logic [REG_WID-1:0]    rs2;
    logic [REG_WID-1:0]    rd;
    logic [XLEN-1:0]       imm;
  } ib_entry_t;

endpackage

// File: rtl/ib_fifo_mem.sv
// Instruction buffer storage: register array, one sync write port, one async read port.
module ib_fifo_mem
  import i_buffer_pkg::*;
#(
  parameter int unsigned DEPTH_LOG = 2,
  parameter int unsigned WID       = IB_ENTRY_WID
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [DEPTH_LOG-1:0] wr_addr,
  input  logic [WID-1:0]       wr_data,
  input  logic [DEPTH_LOG-1:0] rd_addr,
  output logic [WID-1:0]       rd_data
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG;

  logic [WID-1:0] mem_q [DEPTH];

  // Storage is intentionally not reset; validity is tracked by the occupancy count
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/i_buffer.sv
// Circular instruction queue between decode and dispatch; flush empties it on redirect.
module i_buffer
  import i_buffer_pkg::*;
#(
  parameter int unsigned DEPTH_LOG = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    id_valid,
  output logic                    id_vacant,
  input  logic [OPT_WID-1:0]      id_opt,
  input  logic [FUNCT3_WID-1:0]   id_funct3,
  input  logic [FUNCT6_WID-1:0]   id_funct6,
  input  logic [REG_WID-1:0]      id_rs1,
  input  logic [REG_WID-1:0]      id_rs2,
  input  logic [REG_WID-1:0]      id_rd,
  input  logic [XLEN-1:0]         id_imm,
  input  logic                    ds_ready,
  output logic                    ds_valid,
  output logic [OPT_WID-1:0]      ds_opt,
  output logic [FUNCT3_WID-1:0]   ds_funct3,
  output logic [FUNCT6_WID-1:0]   ds_funct6,
  output logic [REG_WID-1:0]      ds_rs1,
  output logic [REG_WID-1:0]      ds_rs2,
  output logic [REG_WID-1:0]      ds_rd,
  output logic [XLEN-1:0]         ds_imm,
  output logic [DEPTH_LOG:0]      ib_count
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG;
  localparam int unsigned CNT_WID = DEPTH_LOG + 1;

  logic [DEPTH_LOG-1:0]    head_q, head_d;
  logic [DEPTH_LOG-1:0]    tail_q, tail_d;
  logic [CNT_WID-1:0]      count_q, count_d;
  logic                    push, pop, wr_en;
  logic [IB_ENTRY_WID-1:0] wr_data, rd_data, ds_entry;

  // Handshakes depend only on registered occupancy: no full-and-pop pass-through
  assign id_vacant = (count_q != CNT_WID'(DEPTH));
  assign ds_valid  = (count_q != '0);
  assign push      = id_valid & id_vacant;
  assign pop       = ds_valid & ds_ready;
  assign ib_count  = count_q;

  // Pack decode fields into one storage word
  always_comb begin
    wr_data = '0;
    wr_data[IB_OPT_LSB    +: OPT_WID]    = id_opt;
    wr_data[IB_FUNCT3_LSB +: FUNCT3_WID] = id_funct3;
    wr_data[IB_FUNCT6_LSB +: FUNCT6_WID] = id_funct6;
    wr_data[IB_RS1_LSB    +: REG_WID]    = id_rs1;
    wr_data[IB_RS2_LSB    +: REG_WID]    = id_rs2;
    wr_data[IB_RD_LSB     +: REG_WID]    = id_rd;
    wr_data[IB_IMM_LSB    +: XLEN]       = id_imm;
  end

  ib_fifo_mem #(
    .DEPTH_LOG (DEPTH_LOG),
    .WID       (IB_ENTRY_WID)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (tail_q),
    .wr_data (wr_data),
    .rd_addr (head_q),
    .rd_data (rd_data)
  );

  // Empty buffer presents zero fields so stale storage never leaks out
  assign ds_entry  = ds_valid ? rd_data : '0;
  assign ds_opt    = ds_entry[IB_OPT_LSB    +: OPT_WID];
  assign ds_funct3 = ds_entry[IB_FUNCT3_LSB +: FUNCT3_WID];
  assign ds_funct6 = ds_entry[IB_FUNCT6_LSB +: FUNCT6_WID];
  assign ds_rs1    = ds_entry[IB_RS1_LSB    +: REG_WID];
  assign ds_rs2    = ds_entry[IB_RS2_LSB    +: REG_WID];
  assign ds_rd     = ds_entry[IB_RD_LSB     +: REG_WID];
  assign ds_imm    = ds_entry[IB_IMM_LSB    +: XLEN];

  // Pointer/occupancy next state; flush overrides any same-cycle push or pop
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wr_en   = 1'b0;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      wr_en = push;
      if (push) tail_d = tail_q + DEPTH_LOG'(1);
      if (pop)  head_d = head_q + DEPTH_LOG'(1);
      if (push && !pop)      count_d = count_q + CNT_WID'(1);
      else if (pop && !push) count_d = count_q - CNT_WID'(1);
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_i_buffer.sv
// Self-checking bench for i_buffer: vector table, corner sequences, random vs queue model.
module tb_i_buffer;
  import i_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, id_valid, ds_ready;
  logic id_vacant, ds_valid;
  logic [OPT_WID-1:0]    ds_opt;
  logic [FUNCT3_WID-1:0] ds_funct3;
  logic [FUNCT6_WID-1:0] ds_funct6;
  logic [REG_WID-1:0]    ds_rs1, ds_rs2, ds_rd;
  logic [XLEN-1:0]       ds_imm;
  logic [2:0]            ib_count;
  ib_entry_t             drv, got;

  int tests = 0;
  int fails = 0;
  ib_entry_t mq[$];

  always #5 clk = ~clk;

  assign got = {ds_opt, ds_funct3, ds_funct6, ds_rs1, ds_rs2, ds_rd, ds_imm};

  i_buffer #(.DEPTH_LOG(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_vacant(id_vacant),
    .id_opt(drv.opt), .id_funct3(drv.funct3), .id_funct6(drv.funct6),
    .id_rs1(drv.rs1), .id_rs2(drv.rs2), .id_rd(drv.rd), .id_imm(drv.imm),
    .ds_ready(ds_ready), .ds_valid(ds_valid),
    .ds_opt(ds_opt), .ds_funct3(ds_funct3), .ds_funct6(ds_funct6),
    .ds_rs1(ds_rs1), .ds_rs2(ds_rs2), .ds_rd(ds_rd), .ds_imm(ds_imm),
    .ib_count(ib_count)
  );

  typedef struct {
    logic        flush, valid, ready;
    logic [31:0] imm;
    int          exp_count;
    logic        exp_valid, exp_vacant;
    logic [31:0] exp_imm;
  } vec_t;

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Compare all outputs against the queue model (empty queue -> zero fields)
  task automatic model_chk(input string nm);
    ib_entry_t e;
    e = (mq.size() != 0) ? mq[0] : '0;
    chk({nm, ".count"},  66'(ib_count),  66'(mq.size()));
    chk({nm, ".valid"},  66'(ds_valid),  66'(mq.size() != 0));
    chk({nm, ".vacant"}, 66'(id_vacant), 66'(mq.size() < 4));
    chk({nm, ".entry"},  66'(got),       66'(e));
  endtask

  // Advance one clock; model applies the buffer rules to the inputs seen at the edge
  task automatic cycle();
    bit do_push, do_pop, do_flush;
    ib_entry_t e;
    do_flush = flush;
    do_pop   = ds_ready && (mq.size() != 0);
    do_push  = id_valid && (mq.size() < 4);
    e        = drv;
    @(posedge clk); #1;
    if (do_flush) mq.delete();
    else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
  endtask

  task automatic idle_inputs();
    flush = 1'b0; id_valid = 1'b0; ds_ready = 1'b0; drv = '0;
  endtask

  vec_t vt[18];

  initial begin
    rst = 1'b0;
    idle_inputs();
    #12;
    chk("reset.valid",  66'(ds_valid),  66'(0));
    chk("reset.vacant", 66'(id_vacant), 66'(1));
    chk("reset.count",  66'(ib_count),  66'(0));
    chk("reset.imm",    66'(ds_imm),    66'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    // Table: fill, overflow drop, full+pop, drain, empty pop, flush priority
    vt[0]  = '{0,1,0, 1, 1,1,1, 1};
    vt[1]  = '{0,1,0, 2, 2,1,1, 1};
    vt[2]  = '{0,1,0, 3, 3,1,1, 1};
    vt[3]  = '{0,1,0, 4, 4,1,0, 1};
    vt[4]  = '{0,1,0, 5, 4,1,0, 1};
    vt[5]  = '{0,1,1, 6, 3,1,1, 2};
    vt[6]  = '{0,1,0, 7, 4,1,0, 2};
    vt[7]  = '{0,0,1, 0, 3,1,1, 3};
    vt[8]  = '{0,0,1, 0, 2,1,1, 4};
    vt[9]  = '{0,0,1, 0, 1,1,1, 7};
    vt[10] = '{0,0,1, 0, 0,0,1, 0};
    vt[11] = '{0,0,1, 0, 0,0,1, 0};
    vt[12] = '{0,1,0, 8, 1,1,1, 8};
    vt[13] = '{0,1,0, 9, 2,1,1, 8};
    vt[14] = '{0,1,0,10, 3,1,1, 8};
    vt[15] = '{1,1,1,11, 0,0,1, 0};
    vt[16] = '{0,1,0,12, 1,1,1,12};
    vt[17] = '{0,0,1, 0, 0,0,1, 0};
    foreach (vt[i]) begin
      flush = vt[i].flush; id_valid = vt[i].valid; ds_ready = vt[i].ready;
      drv = '0; drv.imm = vt[i].imm;
      cycle();
      chk($sformatf("vec%0d.count", i),  66'(ib_count),  66'(vt[i].exp_count));
      chk($sformatf("vec%0d.valid", i),  66'(ds_valid),  66'(vt[i].exp_valid));
      chk($sformatf("vec%0d.vacant", i), 66'(id_vacant), 66'(vt[i].exp_vacant));
      chk($sformatf("vec%0d.imm", i),    66'(ds_imm),    66'(vt[i].exp_imm));
    end
    idle_inputs();

    // Empty + push: not visible same cycle, visible after the edge, fields bit-exact
    drv = '0; drv.opt = 7'b1010111; drv.rd = 6'h21; id_valid = 1'b1;
    #1;
    chk("lat.same_cycle_valid", 66'(ds_valid), 66'(0));
    cycle();
    id_valid = 1'b0;
    chk("lat.valid", 66'(ds_valid), 66'(1));
    chk("lat.opt",   66'(ds_opt),   66'(7'b1010111));
    chk("lat.rd",    66'(ds_rd),    66'(6'h21));
    ds_ready = 1'b1; cycle(); ds_ready = 1'b0;

    // Steady push+pop at count 2 with pointer wrap; order checked through the model
    for (int i = 0; i < 2; i++) begin
      drv = '0; drv.imm = 32'(100 + i); id_valid = 1'b1; cycle();
    end
    ds_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drv = '0; drv.imm = 32'(200 + i); drv.rs1 = 6'(i);
      cycle();
      chk($sformatf("steady%0d.count", i), 66'(ib_count), 66'(2));
      model_chk($sformatf("steady%0d", i));
    end
    idle_inputs();

    // Async reset mid-stream at count 3, then first push visible one cycle later
    ds_ready = 1'b1; cycle(); idle_inputs();
    for (int i = 0; i < 2; i++) begin
      drv = '0; drv.imm = 32'(300 + i); id_valid = 1'b1; cycle();
    end
    idle_inputs();
    chk("pre_rst.count", 66'(ib_count), 66'(3));
    #2 rst = 1'b0;
    #1;
    chk("midrst.valid",  66'(ds_valid),  66'(0));
    chk("midrst.vacant", 66'(id_vacant), 66'(1));
    chk("midrst.count",  66'(ib_count),  66'(0));
    mq.delete();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    drv = '0; drv.imm = 32'h55; id_valid = 1'b1;
    cycle();
    idle_inputs();
    chk("postrst.valid", 66'(ds_valid), 66'(1));
    chk("postrst.imm",   66'(ds_imm),   66'(32'h55));

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      flush    = ($urandom_range(0, 19) == 0);
      id_valid = 1'($urandom_range(0, 1));
      ds_ready = ($urandom_range(0, 2) != 0) ? (i % 64 < 40) : 1'b0;
      drv      = 66'({$urandom(), $urandom(), $urandom()});
      cycle();
      model_chk($sformatf("rnd%0d", i));
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
